// File: rtl/seq_divider16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider16_pkg
// Brief    : Shared constants and state encoding for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
package seq_divider16_pkg;

  localparam int C_WIDTH_DEF = 16;
  localparam int C_CNT_W     = $clog2(C_WIDTH_DEF) + 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_ZERO = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seq_divider16_cla_sub.sv
`default_nettype none
// ============================================================================
// Module   : cla_sub
// Brief    : Carry-lookahead subtractor a - b (b inverted, carry-in 1),
//            4-bit lookahead groups chained by group propagate/generate.
// Revision : 1.0 - initial release
// ============================================================================
module cla_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_n
);

  localparam int C_GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]    w_bn;
  logic [WIDTH-1:0]    w_p;
  logic [WIDTH-1:0]    w_g;
  logic [WIDTH-1:0]    w_c;
  logic [C_GROUPS:0]   w_gc;

  assign w_bn    = ~b;
  assign w_p     = a ^ w_bn;
  assign w_g     = a & w_bn;
  assign w_gc[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < C_GROUPS; gi++) begin : g_grp
      logic [3:0] w_pp;
      logic [3:0] w_gg;
      logic       w_ci;
      logic       w_grp_p;
      logic       w_grp_g;

      assign w_pp = w_p[4*gi +: 4];
      assign w_gg = w_g[4*gi +: 4];
      assign w_ci = w_gc[gi];

      assign w_c[4*gi]   = w_ci;
      assign w_c[4*gi+1] = w_gg[0] | (w_pp[0] & w_ci);
      assign w_c[4*gi+2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_ci);
      assign w_c[4*gi+3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                         | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);

      assign w_grp_p = &w_pp;
      assign w_grp_g = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                     | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);

      assign w_gc[gi+1] = w_grp_g | (w_grp_p & w_ci);
    end
  endgenerate

  assign diff     = w_p ^ w_c;
  assign borrow_n = w_gc[C_GROUPS];

endmodule
`default_nettype wire

// File: rtl/seq_divider16.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider16
// Brief    : Sequential unsigned restoring divider, one trial subtraction
//            per clock, start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int C_CW = $clog2(WIDTH) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_d;
  logic [WIDTH-1:0]  r_r;
  logic [C_CW-1:0]   r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_quot;
  logic [WIDTH-1:0]  r_rem;
  logic              r_dbz;

  logic              w_accept;
  logic              w_load;
  logic              w_iter;
  logic              w_last;
  logic              w_zero_fin;
  logic [WIDTH:0]    w_rsh;
  logic [WIDTH-1:0]  w_diff;
  logic              w_carry;
  logic              w_ge;
  logic [WIDTH-1:0]  w_rnew;
  logic [WIDTH-1:0]  w_qnew;

  // R is stored WIDTH wide: after each step R < D, so the extra bit only
  // exists in the shifted trial value.
  assign w_rsh = {r_r, r_q[WIDTH-1]};

  cla_sub #(.WIDTH(WIDTH)) u_sub (
    .a        (w_rsh[WIDTH-1:0]),
    .b        (r_d),
    .diff     (w_diff),
    .borrow_n (w_carry)
  );

  // A set overflow bit means the shifted remainder already exceeds D.
  assign w_ge   = w_rsh[WIDTH] | w_carry;
  assign w_rnew = w_ge ? w_diff : w_rsh[WIDTH-1:0];
  assign w_qnew = {r_q[WIDTH-2:0], w_ge};
  assign w_last = (r_cnt == C_CW'(WIDTH - 1));

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_next = (divisor == '0) ? ST_ZERO : ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_ZERO: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = w_accept;
    w_iter     = (r_state == ST_RUN);
    w_zero_fin = (r_state == ST_ZERO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_d    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_q    <= dividend;
        r_d    <= divisor;
        r_r    <= '0;
        r_cnt  <= '0;
        r_dbz  <= 1'b0;
        r_busy <= 1'b1;
      end
      if (w_iter) begin
        r_r   <= w_rnew;
        r_q   <= w_qnew;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_quot <= w_qnew;
          r_rem  <= w_rnew;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
      if (w_zero_fin) begin
        r_quot <= '1;
        r_rem  <= r_q;
        r_dbz  <= 1'b1;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider16.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider16
// Brief    : Directed self-checking bench for seq_divider16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  seq_divider16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input int elat, input string nm);
    int n;
    int nb;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n  = 1;
    nb = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== elat) begin
      failures++;
      $display("FAIL %s latency: got %0d edges, expected %0d", nm, n, elat);
    end
    checks++;
    if (nb !== elat - 1) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", nm, nb, elat - 1);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s result: got q=%0d r=%0d z=%b busy=%b, expected q=%0d r=%0d z=%b busy=0",
               nm, quotient, remainder, div_by_zero, busy, eq, er, ez);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      failures++;
      $display("FAIL %s hold: got done=%b q=%0d r=%0d z=%b, expected done=0 q=%0d r=%0d z=%b",
               nm, done, quotient, remainder, div_by_zero, eq, er, ez);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd5;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d z=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_div(16'd100,   16'd7,  16'd14,    16'd2, 1'b0, 17, "div_100_7");
    run_div(16'd65535, 16'd1,  16'd65535, 16'd0, 1'b0, 17, "div_65535_1");
    run_div(16'd5,     16'd10, 16'd0,     16'd5, 1'b0, 17, "div_5_10");
  endtask

  task automatic test_div_zero();
    run_div(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 2, "div_by_zero");
    run_div(16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 17, "dbz_cleared");
  endtask

  task automatic test_start_while_busy();
    int ndone;
    logic [15:0] q_seen;
    logic [15:0] r_seen;
    ndone  = 0;
    q_seen = 16'hDEAD;
    r_seen = 16'hDEAD;
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (c == 5) begin
        dividend = 16'd9;
        divisor  = 16'd2;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        q_seen = quotient;
        r_seen = remainder;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL busy_ignore_pulses: got %0d done pulses, expected 1", ndone);
    end
    checks++;
    if (q_seen !== 16'd333 || r_seen !== 16'd1) begin
      failures++;
      $display("FAIL busy_ignore_result: got q=%0d r=%0d, expected q=333 r=1", q_seen, r_seen);
    end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    dividend = 16'd40000;
    divisor  = 16'd123;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      failures++;
      $display("FAIL abort_state: got busy=%b done=%b q=%0d r=%0d z=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles, expected 0", ndone);
    end
    run_div(16'd40000, 16'd123, 16'd325, 16'd25, 1'b0, 17, "after_abort");
  endtask

  task automatic test_back_to_back();
    int n;
    int gap;
    dividend = 16'd65000;
    divisor  = 16'd250;
    start    = 1'b1;
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 17 || quotient !== 16'd260 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL b2b_first: got edges=%0d q=%0d r=%0d, expected edges=17 q=260 r=0",
               n, quotient, remainder);
    end
    dividend = 16'd17;
    divisor  = 16'd17;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (done !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap !== 17 || quotient !== 16'd1 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL b2b_second: got gap=%0d q=%0d r=%0d, expected gap=17 q=1 r=0",
               gap, quotient, remainder);
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_div_zero();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
